// File: rtl/mem_wb_unit.sv
// mem_wb_unit: memory / writeback back end of the register-block datapath.
// Accepts one operation at a time (valid/ready), performs the data-memory
// load or store over a req/ack handshake, and drives the register-file write
// port. All outputs are registered.
// Optional build macro: MEMWB_TIMEOUT_EN -- bounds the wait for mem_ack to
// TIMEOUT cycles and reports expiry with a one-cycle err pulse. Without it the
// unit waits for ack indefinitely and err is constant 0.
module mem_wb_unit #(
    parameter int RWIDTH  = 6,
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [RWIDTH-1:0] in_rd,
    input  logic [DWIDTH-1:0] in_alu_result,
    input  logic [DWIDTH-1:0] in_store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [RWIDTH-1:0] rf_wa,
    output logic [DWIDTH-1:0] rf_wd,
    output logic              rf_we,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    state_t            state;
    logic [RWIDTH-1:0] rd_q;   // destination captured at accept, used by LOAD writeback

`ifdef MEMWB_TIMEOUT_EN
    localparam int              CW       = $clog2(TIMEOUT + 1);
    // Count value in the MEM cycle in which the count would reach TIMEOUT.
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0]              tmo_cnt;
`endif

    // Single control FSM; every output is a register updated here.
    // in_ready resets low and rises on the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_q      <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rf_wa     <= '0;
            rf_wd     <= '0;
            rf_we     <= 1'b0;
            err       <= 1'b0;
`ifdef MEMWB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            // rf_we and err are single-cycle pulses
            rf_we <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (in_valid && in_ready) begin
                        rd_q <= in_rd;
                        case (in_op)
                            OP_ALU: begin
                                state    <= S_WB;
                                in_ready <= 1'b0;
                                busy     <= 1'b1;
                                // r0 is never written; wa/wd keep their last values
                                if (in_rd != '0) begin
                                    rf_we <= 1'b1;
                                    rf_wa <= in_rd;
                                    rf_wd <= in_alu_result;
                                end
                            end
                            OP_LOAD, OP_STORE: begin
                                state    <= S_MEM;
                                in_ready <= 1'b0;
                                busy     <= 1'b1;
                                mem_req  <= 1'b1;
                                mem_we   <= (in_op == OP_STORE);
                                mem_addr <= in_alu_result[AWIDTH-1:0];
                                if (in_op == OP_STORE)
                                    mem_wdata <= in_store_data;
`ifdef MEMWB_TIMEOUT_EN
                                tmo_cnt  <= '0;
`endif
                            end
                            default: ; // NOP: accepted, nothing changes
                        endcase
                    end
                end

                S_MEM: begin
                    // ack wins even in the cycle the timeout would expire
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state    <= S_IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state <= S_WB;
                            if (rd_q != '0) begin
                                rf_we <= 1'b1;
                                rf_wa <= rd_q;
                                rf_wd <= mem_rdata;
                            end
                        end
                    end
`ifdef MEMWB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        mem_req  <= 1'b0;
                        err      <= 1'b1;
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
`endif
                end

                S_WB: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_unit.sv
// Randomized self-checking bench for mem_wb_unit. A small memory array plays
// the data memory and a shadow of the last register-file write tracks the
// held rf_wa/rf_wd values; expectations follow the operation-level rules.
module tb_mem_wb_unit;
    localparam int RW  = 6;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [RW-1:0] in_rd = '0;
    logic [DW-1:0] in_alu_result = '0;
    logic [DW-1:0] in_store_data = '0;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [RW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          rf_we, busy, err;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem_model [0:63];
    logic [RW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;

    mem_wb_unit #(.RWIDTH(RW), .DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_req"},   mem_req, 0);
        chk({tag, "_we"},    mem_we, 0);
        chk({tag, "_addr"},  mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_wa"},    rf_wa, 0);
        chk({tag, "_wd"},    rf_wd, 0);
        chk({tag, "_rfwe"},  rf_we, 0);
        chk({tag, "_err"},   err, 0);
    endtask

    // Idle cycle with a stray ack and junk read data, both to be ignored.
    task automatic idle_cycle();
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_req", mem_req, 0);
        chk("idle_rfwe", rf_we, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", in_ready, 1);
        chk("idle_err", err, 0);
        chk("idle_wa", rf_wa, last_wa);
        chk("idle_wd", rf_wd, last_wd);
    endtask

    // Issue one operation and follow it to completion; called at a negedge.
    task automatic run_op(input logic [1:0] op, input logic [RW-1:0] rd,
                          input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                          input int delay);
        int n;
        int idx;
        logic [DW-1:0] exp_wd;
        idx = int'(alu[7:2]);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_op", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_alu_result = alu; in_store_data = sd;
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        mem_ack = 1'b0;
        in_op = 2'($urandom); in_rd = RW'($urandom);
        in_alu_result = $urandom; in_store_data = $urandom;
        case (op)
            2'b00: begin
                chk("nop_ready", in_ready, 1);
                chk("nop_busy", busy, 0);
                chk("nop_req", mem_req, 0);
                chk("nop_rfwe", rf_we, 0);
                chk("nop_wa", rf_wa, last_wa);
                chk("nop_wd", rf_wd, last_wd);
            end
            2'b01: begin
                if (rd != 0) begin last_wa = rd; last_wd = alu; end
                chk("alu_rfwe", rf_we, rd != 0);
                chk("alu_wa", rf_wa, last_wa);
                chk("alu_wd", rf_wd, last_wd);
                chk("alu_busy", busy, 1);
                chk("alu_ready_lo", in_ready, 0);
                @(negedge clk);
                chk("alu_ready_hi", in_ready, 1);
                chk("alu_rfwe_end", rf_we, 0);
                chk("alu_busy_end", busy, 0);
            end
            default: begin
                for (int k = 0; k <= delay; k++) begin
                    chk("mem_req", mem_req, 1);
                    chk("mem_we", mem_we, op == 2'b11);
                    chk("mem_addr", mem_addr, alu[AW-1:0]);
                    if (op == 2'b11) chk("mem_wdata", mem_wdata, sd);
                    chk("mem_rfwe", rf_we, 0);
                    chk("mem_ready", in_ready, 0);
                    chk("mem_busy", busy, 1);
                    chk("mem_err", err, 0);
                    mem_ack   = (k == delay);
                    mem_rdata = (k == delay && op == 2'b10) ? mem_model[idx] : $urandom;
                    in_valid  = 1'($urandom);
                    @(negedge clk);
                end
                mem_ack = 1'b0;
                in_valid = 1'b0;
                chk("done_req", mem_req, 0);
                chk("done_err", err, 0);
                if (op == 2'b11) begin
                    mem_model[idx] = sd;
                    chk("st_rfwe", rf_we, 0);
                    chk("st_ready", in_ready, 1);
                    chk("st_busy", busy, 0);
                end else begin
                    exp_wd = mem_model[idx];
                    if (rd != 0) begin last_wa = rd; last_wd = exp_wd; end
                    chk("ld_rfwe", rf_we, rd != 0);
                    chk("ld_wa", rf_wa, last_wa);
                    chk("ld_wd", rf_wd, last_wd);
                    chk("ld_ready_lo", in_ready, 0);
                    @(negedge clk);
                    chk("ld_ready_hi", in_ready, 1);
                    chk("ld_rfwe_end", rf_we, 0);
                end
            end
        endcase
    endtask

    initial begin
        int max_dly;
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
`ifdef MEMWB_TIMEOUT_EN
        max_dly = TMO - 1;
`else
        max_dly = 6;
`endif
        // Reset state while reset is held
        #12;
        chk_all_zero("rst0");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", in_ready, 1);
        chk("rst_rel_busy", busy, 0);

        // Directed cases
        run_op(2'b01, 6'd5, 32'h0000_00AA, 32'h0, 0);
        mem_model[0] = 32'hDEAD_BEEF;
        run_op(2'b10, 6'd3, 32'h0000_0100, 32'h0, 3);
        run_op(2'b11, 6'd9, 32'h0000_0020, 32'h0000_1234, 0);
        run_op(2'b01, 6'd0, 32'h5555_AAAA, 32'h0, 0);
        run_op(2'b10, 6'd0, 32'h0000_0020, 32'h0, 2);
        run_op(2'b10, 6'd63, 32'h0000_0020, 32'h0, 0);
        run_op(2'b00, 6'd7, 32'h1, 32'h2, 0);
        idle_cycle();

        // Randomized operation stream with idle gaps
        for (int t = 0; t < 60; t++) begin
            logic [1:0] op;
            logic [RW-1:0] rd;
            op = 2'($urandom);
            rd = ($urandom_range(0, 4) == 0) ? '0 : RW'($urandom);
            run_op(op, rd, 32'h0000_1000 + ($urandom_range(0, 63) << 2), $urandom,
                   $urandom_range(0, max_dly));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

`ifdef MEMWB_TIMEOUT_EN
        // LOAD with no ack: request held TMO cycles, then err pulse, no writeback
        in_valid = 1'b1; in_op = 2'b10; in_rd = 6'd7; in_alu_result = 32'h40;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            chk("tmo_req", mem_req, 1);
            chk("tmo_err_lo", err, 0);
            @(negedge clk);
        end
        chk("tmo_req_drop", mem_req, 0);
        chk("tmo_err", err, 1);
        chk("tmo_rfwe", rf_we, 0);
        chk("tmo_ready", in_ready, 1);
        @(negedge clk);
        chk("tmo_err_end", err, 0);
        chk("tmo_rfwe_end", rf_we, 0);
`endif

        // Reset asserted mid-cycle during MEM: outputs clear at once, no writeback/err
        in_valid = 1'b1; in_op = 2'b10; in_rd = 6'd11; in_alu_result = 32'h0000_0104;
        @(negedge clk);
        in_valid = 1'b0;
        chk("prerst_req", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b0;
        last_wa = '0;
        last_wd = '0;
        for (int k = 0; k < TMO + 2; k++) begin
            @(negedge clk);
            chk("postrst_req", mem_req, 0);
            chk("postrst_err", err, 0);
            chk("postrst_rfwe", rf_we, 0);
            chk("postrst_ready", in_ready, 1);
        end
        run_op(2'b01, 6'd12, 32'h0BAD_CAFE, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
